// File: rtl/operand_fetch_pkg.sv
// Shared RISC-V decode constants and helpers for the operand fetch stage.
package operand_fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned REG_W   = 5;

  // Base opcodes (instr[6:0])
  localparam logic [OPC_W-1:0] OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] AUIPC  = 7'b0010111;

  // Which producer feeds an operand
  typedef enum logic [2:0] {
    SRC_ZERO = 3'd0,
    SRC_EX   = 3'd1,
    SRC_MEM  = 3'd2,
    SRC_WB   = 3'd3,
    SRC_RF   = 3'd4
  } fwd_src_e;

  // U-type and JAL carry immediate bits in the rs1 field
  function automatic logic uses_rs1(input logic [OPC_W-1:0] opc);
    return !((opc == LUI) || (opc == AUIPC) || (opc == JAL));
  endfunction

  // Only register-register, store and branch formats read rs2
  function automatic logic uses_rs2(input logic [OPC_W-1:0] opc);
    return (opc == OP) || (opc == STORE) || (opc == BRANCH);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass selector: x0, EX, MEM, WB, then register file.
module fwd_mux
  import operand_fetch_pkg::*;
#(
  parameter int unsigned RAWIDTH = 5,
  parameter int unsigned DWIDTH  = 32
) (
  input  logic [RAWIDTH-1:0] i_rs,
  input  logic [DWIDTH-1:0]  i_rf_data,
  input  logic               i_ex_wen,
  input  logic               i_ex_is_load,
  input  logic [RAWIDTH-1:0] i_ex_rd,
  input  logic [DWIDTH-1:0]  i_ex_result,
  input  logic               i_mem_wen,
  input  logic [RAWIDTH-1:0] i_mem_rd,
  input  logic [DWIDTH-1:0]  i_mem_result,
  input  logic               i_wb_wen,
  input  logic [RAWIDTH-1:0] i_wb_rd,
  input  logic [DWIDTH-1:0]  i_wb_data,
  output logic [DWIDTH-1:0]  o_operand_c
);

  fwd_src_e w_src;

  // Youngest matching producer wins; rs==0 short-circuits so rd==0 never forwards
  always_comb begin
    w_src = SRC_RF;
    if (i_rs == '0) begin
      w_src = SRC_ZERO;
    end else if (i_ex_wen && !i_ex_is_load && (i_ex_rd == i_rs)) begin
      w_src = SRC_EX;
    end else if (i_mem_wen && (i_mem_rd == i_rs)) begin
      w_src = SRC_MEM;
    end else if (i_wb_wen && (i_wb_rd == i_rs)) begin
      w_src = SRC_WB;
    end
  end

  // Operand data steering
  always_comb begin
    o_operand_c = i_rf_data;
    case (w_src)
      SRC_ZERO: o_operand_c = '0;
      SRC_EX:   o_operand_c = i_ex_result;
      SRC_MEM:  o_operand_c = i_mem_result;
      SRC_WB:   o_operand_c = i_wb_data;
      default:  o_operand_c = i_rf_data;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// ID stage: register read, operand bypass, load-use hazard and ID/EX register.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned RAWIDTH = 5,
  parameter int unsigned DWIDTH  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [XLEN-1:0]    if_instr,
  input  logic [XLEN-1:0]    if_pc,
  output logic               id_ready,
  output logic [RAWIDTH-1:0] rf_addr_a,
  output logic [RAWIDTH-1:0] rf_addr_b,
  input  logic [DWIDTH-1:0]  rf_data_a,
  input  logic [DWIDTH-1:0]  rf_data_b,
  input  logic               ex_wen,
  input  logic               ex_is_load,
  input  logic [RAWIDTH-1:0] ex_rd,
  input  logic [DWIDTH-1:0]  ex_result,
  input  logic               mem_wen,
  input  logic [RAWIDTH-1:0] mem_rd,
  input  logic [DWIDTH-1:0]  mem_result,
  input  logic               wb_wen,
  input  logic [RAWIDTH-1:0] wb_rd,
  input  logic [DWIDTH-1:0]  wb_data,
  input  logic               ex_stall,
  input  logic               flush,
  output logic               idex_valid,
  output logic [XLEN-1:0]    idex_pc,
  output logic [XLEN-1:0]    idex_instr,
  output logic [RAWIDTH-1:0] idex_rd,
  output logic [RAWIDTH-1:0] idex_rs1,
  output logic [RAWIDTH-1:0] idex_rs2,
  output logic [DWIDTH-1:0]  idex_op_a,
  output logic [DWIDTH-1:0]  idex_op_b,
  output logic               load_use_stall
);

  logic [OPC_W-1:0]   w_opcode;
  logic [RAWIDTH-1:0] w_rs1;
  logic [RAWIDTH-1:0] w_rs2;
  logic [RAWIDTH-1:0] w_rd;
  logic               w_uses_rs1;
  logic               w_uses_rs2;
  logic               w_load_use;
  logic [DWIDTH-1:0]  w_op_a;
  logic [DWIDTH-1:0]  w_op_b;

  logic               r_valid;
  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    r_instr;
  logic [RAWIDTH-1:0] r_rd;
  logic [RAWIDTH-1:0] r_rs1;
  logic [RAWIDTH-1:0] r_rs2;
  logic [DWIDTH-1:0]  r_op_a;
  logic [DWIDTH-1:0]  r_op_b;

  // Field decode
  assign w_opcode   = if_instr[6:0];
  assign w_rs1      = RAWIDTH'(if_instr[19:15]);
  assign w_rs2      = RAWIDTH'(if_instr[24:20]);
  assign w_rd       = RAWIDTH'(if_instr[11:7]);
  assign w_uses_rs1 = uses_rs1(w_opcode);
  assign w_uses_rs2 = uses_rs2(w_opcode);

  assign rf_addr_a  = w_rs1;
  assign rf_addr_b  = w_rs2;

  // Load in EX cannot bypass yet; hold the consumer one cycle until it reaches MEM
  assign w_load_use = if_valid & ex_wen & ex_is_load & (ex_rd != '0) &
                      ((w_uses_rs1 & (w_rs1 == ex_rd)) |
                       (w_uses_rs2 & (w_rs2 == ex_rd)));

  assign load_use_stall = w_load_use;
  assign id_ready       = !ex_stall && !w_load_use;

  fwd_mux #(
    .RAWIDTH (RAWIDTH),
    .DWIDTH  (DWIDTH)
  ) u_fwd_mux_a (
    .i_rs         (w_rs1),
    .i_rf_data    (rf_data_a),
    .i_ex_wen     (ex_wen),
    .i_ex_is_load (ex_is_load),
    .i_ex_rd      (ex_rd),
    .i_ex_result  (ex_result),
    .i_mem_wen    (mem_wen),
    .i_mem_rd     (mem_rd),
    .i_mem_result (mem_result),
    .i_wb_wen     (wb_wen),
    .i_wb_rd      (wb_rd),
    .i_wb_data    (wb_data),
    .o_operand_c  (w_op_a)
  );

  fwd_mux #(
    .RAWIDTH (RAWIDTH),
    .DWIDTH  (DWIDTH)
  ) u_fwd_mux_b (
    .i_rs         (w_rs2),
    .i_rf_data    (rf_data_b),
    .i_ex_wen     (ex_wen),
    .i_ex_is_load (ex_is_load),
    .i_ex_rd      (ex_rd),
    .i_ex_result  (ex_result),
    .i_mem_wen    (mem_wen),
    .i_mem_rd     (mem_rd),
    .i_mem_result (mem_result),
    .i_wb_wen     (wb_wen),
    .i_wb_rd      (wb_rd),
    .i_wb_data    (wb_data),
    .o_operand_c  (w_op_b)
  );

  // ID/EX register: flush > stall hold > load-use bubble > capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (!ex_stall) begin
      r_valid <= if_valid & !w_load_use;
      r_pc    <= if_pc;
      r_instr <= if_instr;
      r_rd    <= w_rd;
      r_rs1   <= w_rs1;
      r_rs2   <= w_rs2;
      r_op_a  <= w_op_a;
      r_op_b  <= w_op_b;
    end
  end

  assign idex_valid = r_valid;
  assign idex_pc    = r_pc;
  assign idex_instr = r_instr;
  assign idex_rd    = r_rd;
  assign idex_rs1   = r_rs1;
  assign idex_rs2   = r_rs2;
  assign idex_op_a  = r_op_a;
  assign idex_op_b  = r_op_b;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: bypass priority, hazards, stall/flush, reset.
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [4:0]  rf_addr_a;
  logic [4:0]  rf_addr_b;
  logic [31:0] rf_data_a;
  logic [31:0] rf_data_b;
  logic        ex_wen;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        mem_wen;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_stall;
  logic        flush;
  logic        idex_valid;
  logic [31:0] idex_pc;
  logic [31:0] idex_instr;
  logic [4:0]  idex_rd;
  logic [4:0]  idex_rs1;
  logic [4:0]  idex_rs2;
  logic [31:0] idex_op_a;
  logic [31:0] idex_op_b;
  logic        load_use_stall;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] rf_mem [32];

  assign rf_data_a = rf_mem[rf_addr_a];
  assign rf_data_b = rf_mem[rf_addr_b];

  operand_fetch #(.RAWIDTH(5), .DWIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .rf_addr_a      (rf_addr_a),
    .rf_addr_b      (rf_addr_b),
    .rf_data_a      (rf_data_a),
    .rf_data_b      (rf_data_b),
    .ex_wen         (ex_wen),
    .ex_is_load     (ex_is_load),
    .ex_rd          (ex_rd),
    .ex_result      (ex_result),
    .mem_wen        (mem_wen),
    .mem_rd         (mem_rd),
    .mem_result     (mem_result),
    .wb_wen         (wb_wen),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .ex_stall       (ex_stall),
    .flush          (flush),
    .idex_valid     (idex_valid),
    .idex_pc        (idex_pc),
    .idex_instr     (idex_instr),
    .idex_rd        (idex_rd),
    .idex_rs1       (idex_rs1),
    .idex_rs2       (idex_rs2),
    .idex_op_a      (idex_op_a),
    .idex_op_b      (idex_op_b),
    .load_use_stall (load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] s_type(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b010, 5'b00000, 7'b0100011};
  endfunction

  // LUI whose immediate places 'fld' in the bit range used by rs1
  function automatic logic [31:0] lui_fld(input logic [4:0] rd, input logic [4:0] fld);
    return {12'h000, fld, 3'b000, rd, 7'b0110111};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_producers();
    ex_wen = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
    mem_wen = 0; mem_rd = 0; mem_result = 0;
    wb_wen = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({idex_valid, idex_pc, idex_instr, idex_rd, idex_rs1, idex_rs2, idex_op_a, idex_op_b} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b pc=%h op_a=%h op_b=%h, required all zero",
               idex_valid, idex_pc, idex_op_a, idex_op_b);
    end
    rst = 0;
    tick();
    tests_run++;
    if ({idex_valid, id_ready, load_use_stall} !== 3'b010) begin
      tests_failed++;
      $display("FAIL idle_after_reset: valid/ready/lus=%b%b%b, required 010",
               idex_valid, id_ready, load_use_stall);
    end
  endtask

  task automatic test_basic();
    if_valid = 1; if_instr = r_type(5'd3, 5'd1, 5'd2); if_pc = 32'h100;
    #1;
    tests_run++;
    if ({rf_addr_a, rf_addr_b, id_ready} !== {5'd1, 5'd2, 1'b1}) begin
      tests_failed++;
      $display("FAIL basic_addr: a=%0d b=%0d ready=%b, required 1 2 1", rf_addr_a, rf_addr_b, id_ready);
    end
    tick();
    tests_run++;
    if ({idex_valid, idex_op_a, idex_op_b} !== {1'b1, 32'd5, 32'd7}) begin
      tests_failed++;
      $display("FAIL basic_ops: valid=%b a=%h b=%h, required 1 5 7", idex_valid, idex_op_a, idex_op_b);
    end
    tests_run++;
    if ({idex_pc, idex_instr, idex_rd, idex_rs1, idex_rs2} !==
        {32'h100, r_type(5'd3, 5'd1, 5'd2), 5'd3, 5'd1, 5'd2}) begin
      tests_failed++;
      $display("FAIL basic_fields: pc=%h instr=%h rd=%0d rs1=%0d rs2=%0d, required 100 add 3 1 2",
               idex_pc, idex_instr, idex_rd, idex_rs1, idex_rs2);
    end
  endtask

  task automatic test_forward_priority();
    if_valid = 1; if_instr = r_type(5'd3, 5'd1, 5'd1); if_pc = 32'h104;
    ex_wen = 1;  ex_rd = 5'd1;  ex_result = 32'h10;
    mem_wen = 1; mem_rd = 5'd1; mem_result = 32'h20;
    wb_wen = 1;  wb_rd = 5'd1;  wb_data = 32'h30;
    tick();
    tests_run++;
    if ({idex_op_a, idex_op_b} !== {32'h10, 32'h10}) begin
      tests_failed++;
      $display("FAIL fwd_ex_first: a=%h b=%h, required 10 10", idex_op_a, idex_op_b);
    end
    ex_wen = 0;
    tick();
    tests_run++;
    if (idex_op_a !== 32'h20) begin
      tests_failed++;
      $display("FAIL fwd_mem_second: a=%h, required 20", idex_op_a);
    end
    mem_wen = 0;
    tick();
    tests_run++;
    if (idex_op_a !== 32'h30) begin
      tests_failed++;
      $display("FAIL fwd_wb_third: a=%h, required 30", idex_op_a);
    end
    wb_wen = 0;
    tick();
    tests_run++;
    if (idex_op_a !== 32'd5) begin
      tests_failed++;
      $display("FAIL fwd_rf_last: a=%h, required 5", idex_op_a);
    end
    if_instr = r_type(5'd3, 5'd1, 5'd2);
    ex_wen = 1;  ex_rd = 5'd2;  ex_result = 32'hAA;
    mem_wen = 1; mem_rd = 5'd1; mem_result = 32'hBB;
    tick();
    tests_run++;
    if ({idex_op_a, idex_op_b} !== {32'hBB, 32'hAA}) begin
      tests_failed++;
      $display("FAIL fwd_split: a=%h b=%h, required bb aa", idex_op_a, idex_op_b);
    end
    clear_producers();
  endtask

  task automatic test_load_use();
    ex_wen = 1; ex_is_load = 1; ex_rd = 5'd5; ex_result = 32'h1234;
    if_valid = 1; if_instr = r_type(5'd6, 5'd5, 5'd0); if_pc = 32'h200;
    #1;
    tests_run++;
    if ({load_use_stall, id_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL lu_detect: lus=%b ready=%b, required 1 0", load_use_stall, id_ready);
    end
    tick();
    tests_run++;
    if (idex_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL lu_bubble: valid=%b, required 0", idex_valid);
    end
    ex_wen = 0; ex_is_load = 0;
    mem_wen = 1; mem_rd = 5'd5; mem_result = 32'hDEAD;
    #1;
    tests_run++;
    if ({load_use_stall, id_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL lu_one_cycle: lus=%b ready=%b, required 0 1", load_use_stall, id_ready);
    end
    tick();
    tests_run++;
    if ({idex_valid, idex_pc, idex_op_a, idex_op_b} !== {1'b1, 32'h200, 32'hDEAD, 32'h0}) begin
      tests_failed++;
      $display("FAIL lu_mem_fwd: valid=%b pc=%h a=%h b=%h, required 1 200 dead 0",
               idex_valid, idex_pc, idex_op_a, idex_op_b);
    end
    mem_wen = 0;
    ex_wen = 1; ex_is_load = 1; ex_rd = 5'd5;
    if_instr = s_type(5'd2, 5'd5); if_pc = 32'h204;
    #1;
    tests_run++;
    if (load_use_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL lu_store_rs2: lus=%b, required 1", load_use_stall);
    end
    if_valid = 0;
    #1;
    tests_run++;
    if (load_use_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL lu_no_valid: lus=%b, required 0", load_use_stall);
    end
    if_valid = 1; if_instr = lui_fld(5'd7, 5'd5); if_pc = 32'h208;
    #1;
    tests_run++;
    if ({load_use_stall, id_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL lu_lui_ignored: lus=%b ready=%b, required 0 1", load_use_stall, id_ready);
    end
    tick();
    tests_run++;
    if ({idex_valid, idex_op_a} !== {1'b1, 32'h105}) begin
      tests_failed++;
      $display("FAIL ex_load_not_fwd: valid=%b a=%h, required 1 105", idex_valid, idex_op_a);
    end
    clear_producers();
  endtask

  task automatic test_x0();
    ex_wen = 1;  ex_rd = 5'd0;  ex_result = 32'hFFFF;
    mem_wen = 1; mem_rd = 5'd0; mem_result = 32'hFFFF;
    wb_wen = 1;  wb_rd = 5'd0;  wb_data = 32'hFFFF;
    if_valid = 1; if_instr = r_type(5'd3, 5'd0, 5'd2); if_pc = 32'h300;
    tick();
    tests_run++;
    if ({idex_op_a, idex_op_b} !== {32'h0, 32'd7}) begin
      tests_failed++;
      $display("FAIL x0_zero: a=%h b=%h, required 0 7", idex_op_a, idex_op_b);
    end
    ex_is_load = 1;
    if_instr = r_type(5'd3, 5'd0, 5'd0);
    #1;
    tests_run++;
    if (load_use_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL x0_no_lu: lus=%b, required 0", load_use_stall);
    end
    clear_producers();
    tick();
  endtask

  task automatic test_stall_flush();
    if_valid = 1; if_instr = r_type(5'd3, 5'd1, 5'd2); if_pc = 32'h400;
    tick();
    ex_stall = 1;
    if_instr = r_type(5'd4, 5'd2, 5'd1); if_pc = 32'h404;
    #1;
    tests_run++;
    if (id_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_ready: ready=%b, required 0", id_ready);
    end
    tick();
    tests_run++;
    if ({idex_valid, idex_pc, idex_rd, idex_op_a, idex_op_b} !== {1'b1, 32'h400, 5'd3, 32'd5, 32'd7}) begin
      tests_failed++;
      $display("FAIL stall_hold: valid=%b pc=%h rd=%0d a=%h b=%h, required 1 400 3 5 7",
               idex_valid, idex_pc, idex_rd, idex_op_a, idex_op_b);
    end
    flush = 1;
    #1;
    tests_run++;
    if (id_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_ready: ready=%b, required 0", id_ready);
    end
    tick();
    tests_run++;
    if ({idex_valid, idex_pc} !== {1'b0, 32'h400}) begin
      tests_failed++;
      $display("FAIL flush_in_stall: valid=%b pc=%h, required 0 400", idex_valid, idex_pc);
    end
    flush = 0;
    ex_wen = 1; ex_rd = 5'd2; ex_result = 32'h10;
    tick();
    tests_run++;
    if ({idex_valid, idex_pc, idex_op_a} !== {1'b0, 32'h400, 32'd5}) begin
      tests_failed++;
      $display("FAIL stall_third: valid=%b pc=%h a=%h, required 0 400 5", idex_valid, idex_pc, idex_op_a);
    end
    ex_wen = 0;
    wb_wen = 1; wb_rd = 5'd2; wb_data = 32'h77;
    ex_stall = 0;
    tick();
    tests_run++;
    if ({idex_valid, idex_pc, idex_op_a, idex_op_b} !== {1'b1, 32'h404, 32'h77, 32'd5}) begin
      tests_failed++;
      $display("FAIL stall_recompute: valid=%b pc=%h a=%h b=%h, required 1 404 77 5",
               idex_valid, idex_pc, idex_op_a, idex_op_b);
    end
    clear_producers();
  endtask

  task automatic test_reset_mid_stall();
    if_valid = 1; if_instr = r_type(5'd5, 5'd1, 5'd2); if_pc = 32'h500;
    tick();
    ex_stall = 1;
    tick();
    #2;
    rst = 1;
    #1;
    tests_run++;
    if ({idex_valid, idex_pc, idex_instr, idex_rd, idex_rs1, idex_rs2, idex_op_a, idex_op_b} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: valid=%b pc=%h a=%h b=%h, required all zero",
               idex_valid, idex_pc, idex_op_a, idex_op_b);
    end
    rst = 0;
    ex_stall = 0;
    if_instr = r_type(5'd6, 5'd2, 5'd1); if_pc = 32'h504;
    tick();
    tests_run++;
    if ({idex_valid, idex_pc, idex_op_a, idex_op_b} !== {1'b1, 32'h504, 32'd7, 32'd5}) begin
      tests_failed++;
      $display("FAIL post_reset_capture: valid=%b pc=%h a=%h b=%h, required 1 504 7 5",
               idex_valid, idex_pc, idex_op_a, idex_op_b);
    end
  endtask

  task automatic test_back_to_back();
    if_valid = 1; if_instr = r_type(5'd8, 5'd1, 5'd2); if_pc = 32'h600;
    tick();
    tests_run++;
    if ({idex_valid, idex_pc, idex_rd} !== {1'b1, 32'h600, 5'd8}) begin
      tests_failed++;
      $display("FAIL b2b_first: valid=%b pc=%h rd=%0d, required 1 600 8", idex_valid, idex_pc, idex_rd);
    end
    ex_wen = 1; ex_rd = 5'd8; ex_result = 32'd12;
    if_instr = r_type(5'd9, 5'd8, 5'd1); if_pc = 32'h604;
    tick();
    tests_run++;
    if ({idex_pc, idex_op_a, idex_op_b} !== {32'h604, 32'd12, 32'd5}) begin
      tests_failed++;
      $display("FAIL b2b_second: pc=%h a=%h b=%h, required 604 c 5", idex_pc, idex_op_a, idex_op_b);
    end
    ex_rd = 5'd9; ex_result = 32'd17;
    mem_wen = 1; mem_rd = 5'd8; mem_result = 32'd12;
    if_instr = r_type(5'd10, 5'd9, 5'd8); if_pc = 32'h608;
    tick();
    tests_run++;
    if ({idex_pc, idex_op_a, idex_op_b} !== {32'h608, 32'd17, 32'd12}) begin
      tests_failed++;
      $display("FAIL b2b_third: pc=%h a=%h b=%h, required 608 11 c", idex_pc, idex_op_a, idex_op_b);
    end
    clear_producers();
    if_valid = 0;
    tick();
    tests_run++;
    if (idex_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_drain: valid=%b, required 0", idex_valid);
    end
  endtask

  initial begin
    rst = 1; if_valid = 0; if_instr = 0; if_pc = 0;
    ex_stall = 0; flush = 0;
    clear_producers();
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h100 + 32'(i);
    rf_mem[0] = 32'hBAD0;
    rf_mem[1] = 32'd5;
    rf_mem[2] = 32'd7;
    test_reset();
    test_basic();
    test_forward_priority();
    test_load_use();
    test_x0();
    test_stall_flush();
    test_reset_mid_stall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter RAWIDTH, default 5, register address width.
REQ-002 Parameter DWIDTH, default 32, data width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 if_valid  in  1  fetch stage presents an instruction.
REQ-006 if_instr, if_pc  in  32 each  instruction word and its PC.
REQ-007 id_ready  out  1  stage accepts the presented instruction this cycle.
REQ-008 rf_addr_a, rf_addr_b  out  RAWIDTH  register-file read addresses, equal to instr[19:15] and instr[24:20].
REQ-009 rf_data_a, rf_data_b  in  DWIDTH  combinational register-file read data.
REQ-010 ex_wen, ex_is_load  in  1 each; ex_rd  in  RAWIDTH; ex_result  in  DWIDTH  EX-stage producer.
REQ-011 mem_wen  in  1; mem_rd  in  RAWIDTH; mem_result  in  DWIDTH  MEM-stage producer.
REQ-012 wb_wen  in  1; wb_rd  in  RAWIDTH; wb_data  in  DWIDTH  same signals that drive register-file write port.
REQ-013 ex_stall  in  1  downstream cannot accept; flush  in  1  kill the instruction held in ID/EX.
REQ-014 idex_valid  out  1; idex_pc, idex_instr  out  32; idex_rd, idex_rs1, idex_rs2  out  RAWIDTH; idex_op_a, idex_op_b  out  DWIDTH.
REQ-015 load_use_stall  out  1  one-cycle hazard bubble indicator.

Function
REQ-016 uses_rs1 SHALL be 0 for LUI, AUIPC, JAL opcodes, else 1; uses_rs2 SHALL be 1 only for R-type, STORE, BRANCH.
REQ-017 Operand select per source, priority: rs==0 -> 0; EX match (ex_wen, ex_rd==rs, !ex_is_load) -> ex_result; MEM match -> mem_result; WB match -> wb_data; else rf data.
REQ-018 A producer with rd==0 SHALL never forward.
REQ-019 WB bypass SHALL cover the same-cycle write/read case, since register-file writes become visible only the following cycle.
REQ-020 load_use_stall SHALL equal if_valid & ex_wen & ex_is_load & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
REQ-021 id_ready SHALL equal !ex_stall & !load_use_stall.
REQ-022 Update priority at each edge: flush -> idex_valid<=0; else ex_stall -> all ID/EX fields hold; else load_use_stall -> idex_valid<=0 (bubble), other fields don't-care; else capture if_valid and all fields.
REQ-023 Latency: operands selected in cycle N appear on idex_* after edge N+1; no other delay.
REQ-024 While stalled, operand selection SHALL be recomputed every cycle so a producer retiring during the stall is picked up.
REQ-025 Flush with simultaneous ex_stall SHALL still clear idex_valid; flush does not alter id_ready.
REQ-026 Load-use stall SHALL last exactly one cycle per load (load leaves EX and match moves to MEM).

Reset
REQ-027 rst asserted SHALL immediately clear idex_valid and all idex_* fields to 0, independent of clk.
REQ-028 Reset mid-stall SHALL discard the held instruction; first post-reset edge with if_valid captures normally.

Structure
REQ-029 Opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC) SHALL live in the shared RISC-V package.
REQ-030 Per-operand priority mux SHALL be one sub-module, fwd_mux, instantiated twice.
REQ-031 Hazard, id_ready and ID/EX register logic SHALL stay in operand_fetch.

Verification
REQ-032 add x3,x1,x2 with rf x1=5, x2=7, no producers -> idex_op_a=5, idex_op_b=7 next edge.
REQ-033 EX writes x1=0x10, MEM writes x1=0x20, WB writes x1=0x30, consumer reads x1 -> op_a=0x10; drop EX -> 0x20; drop MEM -> 0x30.
REQ-034 lw x5 in EX, add x6,x5,x0 presented -> load_use_stall=1, id_ready=0, bubble; next cycle MEM forwards load data 0xDEAD -> op_a=0xDEAD.
REQ-035 Consumer of x0 with all producers writing rd=0 value 0xFFFF -> op_a=0.
REQ-036 ex_stall=1 for 3 cycles -> idex_* unchanged; flush in cycle 2 -> idex_valid=0 despite stall.
REQ-037 rst pulse mid-stall, no clk edge -> idex_valid=0 and fields 0 immediately.
